// File: rtl/sram_controller_pkg.sv
// Shared types for the MEM-stage SRAM bridge: FSM state encoding, operation kind and bus widths.
// Imported by the interface, the controller and the bench.
package sram_controller_pkg;

  localparam int DATA_W            = 32;
  localparam int HALF_W            = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side load/store handshake between the MEM stage (master) and the SRAM bridge (slave).
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two halfword accesses on a 16-bit asynchronous SRAM,
// holding ready low to stall the pipeline until the word is complete.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int PHASE_CYCLES = 2,
  parameter int SRAM_AW      = 18
) (
  input  logic               clk,
  input  logic               reset,
  sram_controller_if.slave   bus,
  inout  wire [HALF_W-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int CW = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(PHASE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  op_e                 op_q, op_d;
  logic [SRAM_AW-2:0]  word_q, word_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic [HALF_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                active_d;
  logic                request;

  logic [DATA_W-1:0]   addr_offset;
  logic [SRAM_AW-2:0]  req_word;
  logic                unused_addr_bits;

  // Word index wraps silently: only SRAM_AW-1 bits survive after removing the data-memory origin.
  assign addr_offset      = bus.address - DATA_W'(BASE_ADDR);
  assign req_word         = addr_offset[SRAM_AW:2];
  assign unused_addr_bits = ^{addr_offset[DATA_W-1:SRAM_AW+1], addr_offset[1:0]};

  assign request = bus.rd_en | bus.wr_en;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (request) begin
          state_d = ST_LOW;
          count_d = '0;
          op_d    = bus.wr_en ? OP_WRITE : OP_READ;
          word_d  = req_word;
          wdata_d = bus.write_data;
        end
      end
      ST_LOW: begin
        if (count_q == LAST_COUNT) begin
          state_d = ST_HIGH;
          count_d = '0;
          if (op_q == OP_READ) rdata_d[HALF_W-1:0] = SRAM_DQ;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (count_q == LAST_COUNT) begin
          state_d = ST_DONE;
          count_d = '0;
          if (op_q == OP_READ) rdata_d[DATA_W-1:HALF_W] = SRAM_DQ;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are precomputed from the next state so each pin comes straight off a flop.
    // WE_N rises on the last cycle of a phase so address and data are held past the write edge.
    active_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
    ce_n_d   = ~active_d;
    oe_n_d   = ~(active_d && (op_d == OP_READ));
    we_n_d   = ~(active_d && (op_d == OP_WRITE) && (count_d != LAST_COUNT));
    dq_oe_d  = active_d && (op_d == OP_WRITE);
    dq_out_d = (state_d == ST_HIGH) ? wdata_d[DATA_W-1:HALF_W] : wdata_d[HALF_W-1:0];
    sram_addr_d = active_d ? {word_d, (state_d == ST_HIGH)} : sram_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      op_q        <= OP_READ;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  // ready is deliberately combinational so a new request freezes the pipeline in its own cycle.
  assign bus.ready     = ((state_q == ST_IDLE) && !request) || (state_q == ST_DONE);
  assign bus.read_data = rdata_q;

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {HALF_W{1'bz}};
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_UB_N = ce_n_q;
  assign SRAM_LB_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural 256Kx16 async SRAM, a directed vector table, hand-written
// multi-cycle sequences and randomized accesses checked against a word-level reference memory.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int P     = 2;
  localparam int BASE  = 1024;
  localparam int AW    = 18;
  localparam int STALL = 1 + 2 * P;

  logic clk;
  logic reset;
  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  sram_controller_if bus ();

  sram_controller #(
    .BASE_ADDR(BASE),
    .PHASE_CYCLES(P),
    .SRAM_AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n),
    .SRAM_OE_N(sram_oe_n),
    .SRAM_CE_N(sram_ce_n),
    .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus while selected for read, latches data while WE_N is low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  wire model_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq = model_drive ? sram_mem[sram_addr] : 16'bz;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && !sram_ub_n && !sram_lb_n) sram_mem[sram_addr] <= sram_dq;
  end

  // Reference model: halfword store keyed by SRAM index, plus the last completed load.
  logic [15:0] ref_mem [int];
  logic [31:0] last_read;

  int total;
  int bad;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_read;
    logic        chk_mem;
    int          idx;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] refGet(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 16'h0;
  endfunction

  task automatic refApply(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] exp_read);
    logic [31:0] w;
    w = ((addr - 32'(BASE)) >> 2) % 32'(1 << (AW - 1));
    if (wr) begin
      ref_mem[int'(2 * w)]     = data[15:0];
      ref_mem[int'(2 * w + 1)] = data[31:16];
    end else if (rd) begin
      last_read = {refGet(int'(2 * w + 1)), refGet(int'(2 * w))};
    end
    exp_read = last_read;
  endtask

  // kind 0: CE/UB/LB (always asserted), 1: OE_N, 2: WE_N; bit k = k-th cycle of the two phases.
  function automatic logic [31:0] expMask(input int kind, input logic is_wr);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 2 * P; k++) begin
      case (kind)
        0:       m[k] = 1'b0;
        1:       m[k] = is_wr;
        default: m[k] = is_wr ? ((k % P) == (P - 1)) : 1'b1;
      endcase
    end
    return m;
  endfunction

  task automatic runAccess(input string tag, output int stall, output logic [31:0] rdata,
                           output logic [31:0] we_m, output logic [31:0] oe_m,
                           output logic [31:0] ce_m);
    we_m = '0;
    oe_m = '0;
    ce_m = '0;
    stall = -1;
    checkOutput({tag, "_ready_drop"}, {31'b0, bus.ready}, 32'h0);
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        stall = k;
        break;
      end
      if (k <= 32) begin
        we_m[k-1] = sram_we_n;
        oe_m[k-1] = sram_oe_n;
        ce_m[k-1] = sram_ce_n | sram_ub_n | sram_lb_n;
      end
    end
    rdata = bus.read_data;
    if (stall < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: ready never returned within 50 cycles", tag);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               output int stall, output logic [31:0] rdata,
                               output logic [31:0] we_m, output logic [31:0] oe_m,
                               output logic [31:0] ce_m);
    bus.rd_en      = rd;
    bus.wr_en      = wr;
    bus.address    = addr;
    bus.write_data = data;
    #1;
    runAccess(tag, stall, rdata, we_m, oe_m, ce_m);
  endtask

  task automatic finishAccess();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAccess(input string tag, input logic wr, input int stall,
                             input logic [31:0] rdata, input logic [31:0] exp_read,
                             input logic [31:0] we_m, input logic [31:0] oe_m,
                             input logic [31:0] ce_m);
    checkOutput({tag, "_stall"}, 32'(stall), 32'(STALL));
    checkOutput({tag, "_read_data"}, rdata, exp_read);
    checkOutput({tag, "_we_n"}, we_m, expMask(2, wr));
    checkOutput({tag, "_oe_n"}, oe_m, expMask(1, wr));
    checkOutput({tag, "_ce_n"}, ce_m, expMask(0, wr));
  endtask

  initial begin
    int          stall;
    logic [31:0] rdata, we_m, oe_m, ce_m, exp_read;
    string       tag;

    total = 0;
    bad = 0;
    last_read = 32'h0;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;

    vecs[0] = '{1'b0, 1'b1, 32'd1024,             32'hDEADBEEF, 32'h00000000, 1'b1, 0, 16'hBEEF, 16'hDEAD};
    vecs[1] = '{1'b1, 1'b0, 32'd1024,             32'h00000000, 32'hDEADBEEF, 1'b0, 0, 16'h0,    16'h0};
    vecs[2] = '{1'b0, 1'b1, 32'd1032,             32'h12345678, 32'hDEADBEEF, 1'b1, 4, 16'h5678, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 32'd1032,             32'h00000000, 32'h12345678, 1'b0, 0, 16'h0,    16'h0};
    vecs[4] = '{1'b1, 1'b1, 32'd1028,             32'hA5A55A5A, 32'h12345678, 1'b1, 2, 16'h5A5A, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b0, 32'd1028,             32'h00000000, 32'hA5A55A5A, 1'b0, 0, 16'h0,    16'h0};
    vecs[6] = '{1'b0, 1'b1, 32'd1024 + (1 << 19), 32'h0BADF00D, 32'hA5A55A5A, 1'b1, 0, 16'hF00D, 16'h0BAD};
    vecs[7] = '{1'b1, 1'b0, 32'd1024,             32'h00000000, 32'h0BADF00D, 1'b0, 0, 16'h0,    16'h0};

    reset = 1'b1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("idle%0d_ready", c), {31'b0, bus.ready}, 32'h1);
      checkOutput($sformatf("idle%0d_strobes", c),
                  {27'b0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
      checkOutput($sformatf("idle%0d_read_data", c), bus.read_data, 32'h0);
      checkOutput($sformatf("idle%0d_sram_addr", c), 32'(sram_addr), 32'h0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(tag, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                    stall, rdata, we_m, oe_m, ce_m);
      refApply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, exp_read);
      checkAccess(tag, vecs[i].wr, stall, rdata, vecs[i].exp_read, we_m, oe_m, ce_m);
      if (vecs[i].chk_mem) begin
        checkOutput({tag, "_mem_lo"}, {16'h0, sram_mem[vecs[i].idx]},     {16'h0, vecs[i].exp_lo});
        checkOutput({tag, "_mem_hi"}, {16'h0, sram_mem[vecs[i].idx + 1]}, {16'h0, vecs[i].exp_hi});
      end
      finishAccess();
    end

    // Back-to-back loads: request held through DONE, second address presented for the next IDLE.
    applyStimulus("b2b0", 1'b1, 1'b0, 32'd1024, 32'h0, stall, rdata, we_m, oe_m, ce_m);
    refApply(1'b1, 1'b0, 32'd1024, 32'h0, exp_read);
    checkAccess("b2b0", 1'b0, stall, rdata, exp_read, we_m, oe_m, ce_m);
    bus.address = 32'd1028;
    @(posedge clk);
    #1;
    runAccess("b2b1", stall, rdata, we_m, oe_m, ce_m);
    refApply(1'b1, 1'b0, 32'd1028, 32'h0, exp_read);
    checkAccess("b2b1", 1'b0, stall, rdata, exp_read, we_m, oe_m, ce_m);
    finishAccess();

    // Reset landing in the HIGH phase of a load discards the partial word.
    bus.rd_en = 1'b1;
    bus.address = 32'd1032;
    #1;
    repeat (1 + P) @(posedge clk);
    #1;
    checkOutput("midrst_active_ce", {31'b0, sram_ce_n}, 32'h0);
    reset = 1'b1;
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_read = 32'h0;
    checkOutput("midrst_strobes", {27'b0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
    checkOutput("midrst_read_data", bus.read_data, 32'h0);
    checkOutput("midrst_ready", {31'b0, bus.ready}, 32'h1);
    applyStimulus("postrst", 1'b1, 1'b0, 32'd1032, 32'h0, stall, rdata, we_m, oe_m, ce_m);
    refApply(1'b1, 1'b0, 32'd1032, 32'h0, exp_read);
    checkAccess("postrst", 1'b0, stall, rdata, exp_read, we_m, oe_m, ce_m);
    finishAccess();

    for (int t = 0; t < 40; t++) begin
      logic        rd, wr;
      logic [31:0] addr, data;
      int          kind, mode, woff;
      kind = int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 3));
      woff = int'($urandom_range(0, 15));
      rd = (kind != 1);
      wr = (kind != 0);
      if (mode == 0)      addr = 32'(BASE) + 32'(4 * (woff + (1 << 17)));
      else if (mode == 1) addr = 32'(BASE) - 32'(4 * (woff + 1));
      else                addr = 32'(BASE) + 32'(4 * woff);
      data = $urandom;
      tag = $sformatf("rnd%0d", t);
      applyStimulus(tag, rd, wr, addr, data, stall, rdata, we_m, oe_m, ce_m);
      refApply(rd, wr, addr, data, exp_read);
      checkAccess(tag, wr, stall, rdata, exp_read, we_m, oe_m, ce_m);
      finishAccess();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
